// File: rtl/im_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// im_port_arbiter_if -- fetch, loader and memory-port signals of the arbiter
// Rev 1.0
// ============================================================================
interface im_port_arbiter_if;
   logic        boot_done;
   logic        in_boot;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_gnt;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic        fetch_adel;
   logic        ld_req;
   logic [31:0] ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_ack;
   logic        ld_err;
   logic [11:0] mem_idx;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  boot_done, fetch_req, fetch_pc, ld_req, ld_addr, ld_wdata, mem_rdata,
      output in_boot, fetch_gnt, fetch_valid, fetch_instr, fetch_adel,
             ld_ack, ld_err, mem_idx, mem_we, mem_wdata
   );

   modport master (
      output boot_done, fetch_req, fetch_pc, ld_req, ld_addr, ld_wdata, mem_rdata,
      input  in_boot, fetch_gnt, fetch_valid, fetch_instr, fetch_adel,
             ld_ack, ld_err, mem_idx, mem_we, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/im_port_arbiter.sv
`default_nettype none
// ============================================================================
// im_port_arbiter -- shares one instruction-memory port between boot loader
// and fetch stage, with a bounded loader burst while fetch waits.  Rev 1.0
// ============================================================================
module im_port_arbiter #(
   parameter logic [31:0] BASE_PC      = 32'h0000_3000,
   parameter int unsigned IM_WORDS     = 4096,
   parameter int unsigned MAX_LD_BURST = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   im_port_arbiter_if.slave   bus
);
   localparam int unsigned           STREAK_W   = $clog2(MAX_LD_BURST + 1);
   localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_LD_BURST);
   localparam logic [32:0]           ADDR_LO    = {1'b0, BASE_PC};
   localparam logic [32:0]           ADDR_HI    = {1'b0, BASE_PC} + (33'(IM_WORDS) << 2);
   localparam logic [0:0]            ST_BOOT    = 1'b0;
   localparam logic [0:0]            ST_RUN     = 1'b1;

   function automatic logic addr_ok(input logic [31:0] a);
      return ({1'b0, a} >= ADDR_LO) && ({1'b0, a} < ADDR_HI) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [11:0] addr_idx(input logic [31:0] a);
      return 12'((a[13:0] - BASE_PC[13:0]) >> 2);
   endfunction

   logic [0:0]          state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                fvalid_q;
   logic                fadel_q;
   logic [31:0]         finstr_q;
   logic                ld_gnt;
   logic                f_gnt;
   logic                ld_ok;
   logic                f_ok;

   assign ld_ok = addr_ok(bus.ld_addr);
   assign f_ok  = addr_ok(bus.fetch_pc);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_BOOT;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == ST_BOOT && bus.boot_done) begin
         state_d = ST_RUN;
      end
   end

   // Grants are forced low while reset is held so no write slips through.
   always_comb begin
      ld_gnt = 1'b0;
      f_gnt  = 1'b0;
      if (rst_ni) begin
         case (state_q)
            ST_BOOT: ld_gnt = bus.ld_req;
            default: begin
               ld_gnt = bus.ld_req && (!bus.fetch_req || streak_q < STREAK_MAX);
               f_gnt  = bus.fetch_req && !ld_gnt;
            end
         endcase
      end
   end

   always_comb begin
      streak_d = streak_q;
      if (!bus.fetch_req || f_gnt) begin
         streak_d = '0;
      end else if (ld_gnt && streak_q != STREAK_MAX) begin
         streak_d = streak_q + STREAK_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fvalid_q <= 1'b0;
         fadel_q  <= 1'b0;
         finstr_q <= '0;
      end else begin
         fvalid_q <= f_gnt;
         if (f_gnt) begin
            fadel_q  <= !f_ok;
            finstr_q <= f_ok ? bus.mem_rdata : 32'h0;
         end
      end
   end

   assign bus.in_boot     = (state_q == ST_BOOT);
   assign bus.fetch_gnt   = f_gnt;
   assign bus.fetch_valid = fvalid_q;
   assign bus.fetch_instr = finstr_q;
   assign bus.fetch_adel  = fadel_q;
   assign bus.ld_ack      = ld_gnt;
   assign bus.ld_err      = ld_gnt && !ld_ok;
   assign bus.mem_we      = ld_gnt && ld_ok;
   assign bus.mem_idx     = ld_gnt ? addr_idx(bus.ld_addr) : addr_idx(bus.fetch_pc);
   assign bus.mem_wdata   = bus.ld_wdata;
endmodule
`default_nettype wire

// File: doc/im_port_arbiter.md
IM_PORT_ARBITER -- requirements
Module: im_port_arbiter

Interface
REQ-001 SHALL have parameter BASE_PC, default 32'h0000_3000: byte address of instruction-memory word 0.
REQ-002 SHALL have parameter IM_WORDS, default 4096: memory depth in 32-bit words, with 12-bit index.
REQ-003 SHALL have parameter MAX_LD_BURST, default 4: maximum consecutive loader grants while fetch waits.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 boot_done  in  1  one-cycle pulse ending boot-load phase.
REQ-007 fetch_req  in  1  fetch stage requests an instruction; held until fetch_gnt.
REQ-008 fetch_pc  in  32  byte address of requested instruction.
REQ-009 fetch_gnt  out  1  combinational; fetch served this cycle.
REQ-010 fetch_valid  out  1  registered; fetch_instr/fetch_adel valid this cycle.
REQ-011 fetch_instr  out  32  registered instruction word.
REQ-012 fetch_adel  out  1  registered; fetch address error.
REQ-013 ld_req  in  1  loader write request; held until ld_ack.
REQ-014 ld_addr  in  32  byte address to write.
REQ-015 ld_wdata  in  32  word to write.
REQ-016 ld_ack  out  1  combinational; loader served this cycle.
REQ-017 ld_err  out  1  combinational, qualified by ld_ack; write rejected.
REQ-018 mem_idx  out  12  word index to memory (async-read, sync-write array).
REQ-019 mem_we  out  1  memory write enable, committed at end of cycle.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_rdata  in  32  combinational read data for mem_idx.
REQ-022 in_boot  out  1  high while in BOOT state.

Function
REQ-023 Address valid iff BASE_PC <= addr < BASE_PC+4*IM_WORDS and addr[1:0]==0; index = (addr-BASE_PC)[13:2].
REQ-024 States: BOOT (reset state) and RUN. BOOT->RUN on boot_done; RUN has no exit except reset.
REQ-025 In BOOT, fetch_gnt = 0 regardless of fetch_req; loader is served every cycle ld_req is high.
REQ-026 In RUN, a single memory access per cycle: grant to loader when only ld_req is high, to fetch when only fetch_req is high.
REQ-027 In RUN with both requesting, grant loader if ld_streak < MAX_LD_BURST, else grant fetch.
REQ-028 ld_streak counts consecutive loader grants made while fetch_req is high; it clears on any fetch grant or any cycle where fetch_req is low, and saturates at MAX_LD_BURST.
REQ-029 Loader grant, valid address: ld_ack=1, ld_err=0, mem_we=1, mem_idx=index, mem_wdata=ld_wdata.
REQ-030 Loader grant, invalid address: ld_ack=1, ld_err=1, mem_we=0.
REQ-031 Fetch grant, valid address: fetch_gnt=1, mem_idx=index; next cycle fetch_valid=1, fetch_instr=mem_rdata sampled at grant, fetch_adel=0.
REQ-032 Fetch grant, invalid address: next cycle fetch_valid=1, fetch_instr=0, fetch_adel=1.
REQ-033 Fetch latency is one cycle from grant; fetch_valid is high for exactly one cycle per grant and is low in any cycle not following a fetch grant.
REQ-034 A write granted in cycle T is visible to a fetch of the same index granted in T+1 or later.
REQ-035 When no write is granted, mem_we=0; mem_idx and mem_wdata are don't-care.
REQ-036 boot_done in the same cycle as ld_req in BOOT: the loader is still served and the state becomes RUN next cycle.

Reset
REQ-037 While reset is low: state=BOOT, ld_streak=0, fetch_valid=0, fetch_instr=0, fetch_adel=0, mem_we=0, fetch_gnt=0, ld_ack=0.
REQ-038 Reset asserted mid-operation discards any pending fetch response; no fetch_valid follows reset release until a new grant.

Verification
REQ-039 Reset, ld_req with addr 32'h3000 and data 32'h2408_0001 in BOOT, fetch_req held -> ld_ack=1, mem_we=1, mem_idx=0; fetch_gnt stays 0 until boot_done.
REQ-040 RUN, fetch_pc 32'h4180 after loader wrote 32'h4210_0018 there -> fetch_gnt at T, fetch_valid at T+1, fetch_instr=32'h4210_0018, fetch_adel=0.
REQ-041 RUN, fetch_pc 32'h3002 and separately 32'h2FFC -> each gives fetch_valid=1, fetch_instr=0, fetch_adel=1, mem_we=0.
REQ-042 RUN, ld_req and fetch_req held continuously -> grant pattern is 4 ld_ack followed by 1 fetch_gnt, repeating.
REQ-043 ld_addr 32'h7000 -> ld_ack=1, ld_err=1, mem_we=0.
REQ-044 Reset pulled low in the cycle after a fetch grant -> fetch_valid=0 and state=BOOT after release.
